// File: rtl/mcycle_sched_pkg.sv
// Shared types and constants for the multicycle multiply/divide scheduler.
package mcycle_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Operation type handed to the arithmetic unit.
    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e_t;

    // Default RUN budget: a 32-cycle divide plus margin.
    localparam int TIMEOUT_DEFAULT = 40;

    // Register-number comparator used by the hazard detector.
    function automatic logic reg_match(input logic [3:0] a, input logic [3:0] b);
        return (a == b);
    endfunction

endpackage

// File: rtl/mcycle_hazard.sv
// Decode-stage hazard detection against an in-flight multicycle instruction.
// Flags a structural hazard (another multicycle op) or a RAW/WAW hazard on
// the destination register still owned by the multicycle unit.
module mcycle_hazard
    import mcycle_sched_pkg::*;
(
    input  logic       busy,
    input  logic [3:0] busy_rd,
    input  logic       dec_valid,
    input  logic       dec_mcycle,
    input  logic [3:0] dec_rn,
    input  logic [3:0] dec_rm,
    input  logic [3:0] dec_rd,
    output logic       hazard
);

    logic reg_hit_s;

    // Combine the structural and register-dependency conditions.
    always_comb begin
        reg_hit_s = reg_match(dec_rn, busy_rd) |
                    reg_match(dec_rm, busy_rd) |
                    reg_match(dec_rd, busy_rd);
        if (busy && dec_valid) begin
            hazard = dec_mcycle | reg_hit_s;
        end else begin
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/mcycle_sched.sv
// Multicycle multiply/divide scheduler: launches the arithmetic unit, stalls
// dependent Decode instructions, inserts the result write into a free slot and
// aborts with a sticky error if the unit never completes.
module mcycle_sched
    import mcycle_sched_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       start_e,
    input  logic       op_e,
    input  logic [3:0] rd_e,
    input  logic       flush_e,
    input  logic       m_done,
    input  logic       dec_valid,
    input  logic       dec_mcycle,
    input  logic [3:0] dec_rn,
    input  logic [3:0] dec_rm,
    input  logic [3:0] dec_rd,
    input  logic       wb_slot_busy,
    output logic       m_start,
    output logic       m_op,
    output logic       stall_fd,
    output logic       out_valid,
    output logic [3:0] wb_rd,
    output logic       busy,
    output logic       err_timeout
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_r;
    state_e           state_s;
    logic [CNT_W-1:0] cnt_r;
    op_e_t            op_r;
    logic [3:0]       rd_r;
    logic             m_start_r;
    logic             err_r;
    logic             accept_s;
    logic             timeout_s;
    logic             out_valid_s;
    logic             busy_s;
    logic             hazard_s;

    // Next-state and control decode; m_done wins over timeout on the last cycle.
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        timeout_s   = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_e && !flush_e) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_s = 1'b1;
                if (m_done) begin
                    state_s = ST_WB;
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = ST_IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_WB: begin
                busy_s = 1'b1;
                if (!wb_slot_busy) begin
                    out_valid_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s     = ST_WB;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latched operands, launch pulse, saturating RUN counter and sticky error.
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            cnt_r     <= '0;
            op_r      <= OP_MUL;
            rd_r      <= 4'd0;
            m_start_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            m_start_r <= accept_s;
            if (accept_s) begin
                op_r  <= op_e_t'(op_e);
                rd_r  <= rd_e;
                cnt_r <= '0;
            end else if ((state_r == ST_RUN) && (cnt_r != CNT_LAST)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end
        end
    end

    mcycle_hazard u_hazard (
        .busy       (busy_s),
        .busy_rd    (rd_r),
        .dec_valid  (dec_valid),
        .dec_mcycle (dec_mcycle),
        .dec_rn     (dec_rn),
        .dec_rm     (dec_rm),
        .dec_rd     (dec_rd),
        .hazard     (hazard_s)
    );

    // The write slot is released in the out_valid cycle, so the stall drops with it.
    assign stall_fd    = hazard_s & ~out_valid_s;
    assign out_valid   = out_valid_s;
    assign busy        = busy_s;
    assign m_start     = m_start_r;
    assign m_op        = op_r;
    assign wb_rd       = rd_r;
    assign err_timeout = err_r;

endmodule

// File: tb/tb_mcycle_sched.sv
// Directed self-checking bench for mcycle_sched with a writeback scoreboard.
module tb_mcycle_sched;
    import mcycle_sched_pkg::*;

    logic       CLK = 1'b0;
    logic       Reset_n;
    logic       start_e;
    logic       op_e;
    logic [3:0] rd_e;
    logic       flush_e;
    logic       m_done;
    logic       dec_valid;
    logic       dec_mcycle;
    logic [3:0] dec_rn;
    logic [3:0] dec_rm;
    logic [3:0] dec_rd;
    logic       wb_slot_busy;
    logic       m_start;
    logic       m_op;
    logic       stall_fd;
    logic       out_valid;
    logic [3:0] wb_rd;
    logic       busy;
    logic       err_timeout;

    int         tests = 0;
    int         fails = 0;
    logic [3:0] sb[$];

    mcycle_sched #(.TIMEOUT(TIMEOUT_DEFAULT)) dut (
        .CLK          (CLK),
        .Reset_n      (Reset_n),
        .start_e      (start_e),
        .op_e         (op_e),
        .rd_e         (rd_e),
        .flush_e      (flush_e),
        .m_done       (m_done),
        .dec_valid    (dec_valid),
        .dec_mcycle   (dec_mcycle),
        .dec_rn       (dec_rn),
        .dec_rm       (dec_rm),
        .dec_rd       (dec_rd),
        .wb_slot_busy (wb_slot_busy),
        .m_start      (m_start),
        .m_op         (m_op),
        .stall_fd     (stall_fd),
        .out_valid    (out_valid),
        .wb_rd        (wb_rd),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_o(input string tag, input logic e_start, input logic e_op,
                         input logic e_stall, input logic e_ov, input logic e_busy,
                         input logic e_err);
        chk({tag, "_m_start"},  m_start,     e_start);
        chk({tag, "_m_op"},     m_op,        e_op);
        chk({tag, "_stall"},    stall_fd,    e_stall);
        chk({tag, "_outvalid"}, out_valid,   e_ov);
        chk({tag, "_busy"},     busy,        e_busy);
        chk({tag, "_err"},      err_timeout, e_err);
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    // Scoreboard: every writeback must match the oldest expected destination.
    always @(negedge CLK) begin
        if (out_valid === 1'b1) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL sb_unexpected_wb observed=%0h expected=none", wb_rd);
            end
            if (sb.size() > 0) begin
                chk("sb_wb_rd", wb_rd, sb.pop_front());
            end
        end
    end

    initial begin
        Reset_n = 1'b0; start_e = 1'b0; op_e = 1'b0; rd_e = 4'd0; flush_e = 1'b0;
        m_done = 1'b0; dec_valid = 1'b0; dec_mcycle = 1'b0; dec_rn = 4'd0;
        dec_rm = 4'd0; dec_rd = 4'd0; wb_slot_busy = 1'b0;
        nxt(); nxt();
        Reset_n = 1'b1;
        // Reset state; a decode hazard on r0 must not stall while idle.
        dec_valid = 1'b1; dec_mcycle = 1'b1;
        smp(); chk_o("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_wb_rd", wb_rd, 4'd0);
        nxt();
        dec_valid = 1'b0; dec_mcycle = 1'b0;

        // Multiply to r5, unit completes 3 cycles after m_start: latency 5.
        start_e = 1'b1; op_e = OP_MUL; rd_e = 4'd5; sb.push_back(4'd5);
        smp(); chk_o("t1_c0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nxt(); start_e = 1'b0;
        smp(); chk_o("t1_c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nxt(); start_e = 1'b1; op_e = OP_DIV; rd_e = 4'd9;   // ignored while busy
        smp(); chk_o("t1_c2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nxt(); start_e = 1'b0;
        smp(); chk("t1_c3_ov", out_valid, 1'b0);
        nxt(); m_done = 1'b1;
        smp(); chk_o("t1_c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nxt(); m_done = 1'b0;
        smp(); chk_o("t1_c5", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t1_c5_wb_rd", wb_rd, 4'd5);
        nxt(); m_done = 1'b1;                               // ignored in IDLE
        smp(); chk_o("t1_c6", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nxt(); m_done = 1'b0;
        smp(); chk_o("t1_c7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nxt();

        // Divide to r3 with decode hazards on each register field.
        start_e = 1'b1; op_e = OP_DIV; rd_e = 4'd3; sb.push_back(4'd3);
        nxt(); start_e = 1'b0;
        dec_valid = 1'b1; dec_rn = 4'd3; dec_rm = 4'd7; dec_rd = 4'd8;
        smp(); chk_o("t2_rn3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        nxt(); dec_rn = 4'd4;
        smp(); chk("t2_rn4_stall", stall_fd, 1'b0);
        nxt(); dec_rm = 4'd3;
        smp(); chk("t2_rm3_stall", stall_fd, 1'b1);
        nxt(); dec_rm = 4'd7; dec_rd = 4'd3;
        smp(); chk("t2_rd3_stall", stall_fd, 1'b1);
        nxt(); dec_rd = 4'd8; dec_mcycle = 1'b1;
        smp(); chk("t2_mcyc_stall", stall_fd, 1'b1);
        nxt(); dec_mcycle = 1'b0; dec_rn = 4'd3; dec_valid = 1'b0;
        smp(); chk("t2_novalid_stall", stall_fd, 1'b0);
        nxt(); dec_valid = 1'b1; m_done = 1'b1;
        smp(); chk("t2_done_stall", stall_fd, 1'b1);
        nxt(); m_done = 1'b0;
        smp(); chk_o("t2_wb", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        nxt();
        smp(); chk_o("t2_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        nxt(); dec_valid = 1'b0; dec_rn = 4'd0; dec_rm = 4'd0; dec_rd = 4'd0;

        // Write slot busy for two cycles holds WB; write lands on the third.
        start_e = 1'b1; op_e = OP_MUL; rd_e = 4'd10; sb.push_back(4'd10);
        nxt(); start_e = 1'b0; m_done = 1'b1;
        smp(); chk("t3_m_start", m_start, 1'b1);
        nxt(); m_done = 1'b0; wb_slot_busy = 1'b1; dec_valid = 1'b1; dec_rn = 4'd10;
        smp(); chk_o("t3_hold1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        nxt();
        smp(); chk_o("t3_hold2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        nxt(); wb_slot_busy = 1'b0;
        smp(); chk_o("t3_wb", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_wb_rd", wb_rd, 4'd10);
        nxt();
        smp(); chk("t3_idle_busy", busy, 1'b0);
        nxt(); dec_valid = 1'b0; dec_rn = 4'd0;

        // Start killed by a flush in the same cycle.
        start_e = 1'b1; flush_e = 1'b1; rd_e = 4'd6;
        nxt(); start_e = 1'b0; flush_e = 1'b0;
        smp(); chk_o("t4_flush", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nxt();
        smp(); chk("t4_flush_busy2", busy, 1'b0);

        // No completion: 40 RUN cycles, then abort with the sticky error.
        start_e = 1'b1; op_e = OP_DIV; rd_e = 4'd2;
        nxt(); start_e = 1'b0;
        for (int i = 0; i < TIMEOUT_DEFAULT; i++) begin
            smp();
            chk("t5_run_busy", busy, 1'b1);
            chk("t5_run_err", err_timeout, 1'b0);
            nxt();
        end
        smp(); chk_o("t5_abort", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        nxt();
        smp(); chk("t5_err_sticky", err_timeout, 1'b1);
        nxt();

        // Reset in the middle of RUN; a late m_done must be ignored.
        start_e = 1'b1; op_e = OP_DIV; rd_e = 4'd7;
        nxt(); start_e = 1'b0;
        smp(); chk_o("t6_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        nxt(); Reset_n = 1'b0;
        nxt(); Reset_n = 1'b1; m_done = 1'b1;
        smp(); chk_o("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_rst_wb_rd", wb_rd, 4'd0);
        nxt(); m_done = 1'b0;
        smp(); chk_o("t6_late_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nxt();

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mcycle_sched.md
MCYCLE_SCHED -- requirements
Module: mcycle_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 40, giving the maximum cycles in RUN before abort (covers a 32-cycle divide plus margin).
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset_n, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have port start_e, input, 1, meaning a condition-passed multiply/divide instruction is in Execute.
REQ-005 The block SHALL have port op_e, input, 1, meaning the operation type: 0 multiply, 1 divide.
REQ-006 The block SHALL have port rd_e, input, 4, the destination register of the multicycle instruction.
REQ-007 The block SHALL have port flush_e, input, 1, meaning a branch is taken in Execute and the Execute instruction is killed.
REQ-008 The block SHALL have port m_done, input, 1, the completion pulse from the multicycle arithmetic unit.
REQ-009 The block SHALL have ports dec_valid (1), dec_mcycle (1), dec_rn (4), dec_rm (4), dec_rd (4), all inputs, describing the Decode-stage instruction.
REQ-010 The block SHALL have port wb_slot_busy, input, 1, meaning a regular instruction in Execute claims the register-write slot this cycle.
REQ-011 The block SHALL have ports m_start (1) and m_op (1), both outputs, giving the start pulse and latched op to the arithmetic unit.
REQ-012 The block SHALL have port stall_fd, output, 1, which stalls Fetch and Decode and bubbles Execute.
REQ-013 The block SHALL have ports out_valid (1) and wb_rd (4), both outputs, which insert the result write (MCycle_out_signal role).
REQ-014 The block SHALL have ports busy (1) and err_timeout (1), both outputs, meaning the unit is occupied and the sticky timeout flag respectively.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and WB; busy SHALL be high in RUN and WB.
REQ-016 In IDLE, when start_e=1 and flush_e=0, the block SHALL latch op_e and rd_e, clear the counter and enter RUN; when flush_e=1 it SHALL stay in IDLE.
REQ-017 m_start SHALL be high for exactly the first RUN cycle, one cycle after acceptance; m_op SHALL hold the latched op throughout RUN and WB.
REQ-018 In RUN the counter SHALL increment each cycle; m_done=1 SHALL move the FSM to WB on the next edge.
REQ-019 If the counter reaches TIMEOUT-1 in RUN without m_done, the block SHALL set err_timeout (cleared only by reset) and return to IDLE with no writeback.
REQ-020 In WB with wb_slot_busy=0, the block SHALL assert out_valid for one cycle with wb_rd equal to the latched rd, then go to IDLE; with wb_slot_busy=1 it SHALL hold in WB with out_valid=0.
REQ-021 The minimum start_e-to-out_valid latency SHALL be unit latency + 2 cycles.
REQ-022 When busy=1 and dec_valid=1, stall_fd SHALL be asserted if dec_mcycle=1, or dec_rn, dec_rm or dec_rd equals the latched rd (RAW/WAW hazard).
REQ-023 stall_fd SHALL deassert in the same cycle that out_valid is high, so a dependent instruction reaches Execute after the write.
REQ-024 m_done outside RUN SHALL be ignored, and start_e outside IDLE SHALL be ignored.
REQ-025 The counter SHALL be ceil(log2(TIMEOUT)) bits wide and SHALL never wrap.

Reset
REQ-026 When Reset_n=0 at a clock edge, the block SHALL enter IDLE with m_start, m_op, stall_fd, out_valid, busy and err_timeout at 0, and wb_rd and the counter at 0, including mid-RUN or mid-WB.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE/RUN/WB), the op encodings MUL=0 and DIV=1, and the default TIMEOUT constant.
REQ-028 One sub-module, mcycle_hazard (combinational register comparators), SHALL be used; the FSM and counter SHALL stay in the top level.

Verification
REQ-029 The bench SHALL cover: start_e=1, op_e=0, rd_e=5, m_done after 3 cycles, wb_slot_busy=0 -> one m_start pulse, out_valid with wb_rd=5 one cycle after m_done, total latency 5.
REQ-030 The bench SHALL cover: divide busy with rd=3, decode dec_rn=3 -> stall_fd high until the out_valid cycle; with decode dec_rn=4 -> no stall.
REQ-031 The bench SHALL cover: m_done while wb_slot_busy=1 for 2 cycles -> FSM holds in WB, then out_valid on the third cycle.
REQ-032 The bench SHALL cover: start_e and flush_e together -> no m_start, busy stays 0.
REQ-033 The bench SHALL cover: no m_done for 40 cycles -> err_timeout=1, return to IDLE, no out_valid.
REQ-034 The bench SHALL cover: Reset_n=0 mid-RUN -> all outputs 0 next edge, and a late m_done is ignored.
